mdu: RTL and testbench

- Multiply/divide unit for the P5/P6 MIPS core's EX stage, beside the ALU.
- Executes MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency and commits results to internal HI/LO registers.
- Also executes MTHI/MTLO writes.
- Its read port (MFHI/MFLO) is a result source for the register write-data mux, alongside ALU, memory and link data.
- Asserts Busy so the hazard controller can stall later MDU instructions.

---
 rtl/mdu_pkg.sv | 23 ++
 rtl/mdu_calc.sv | 66 ++++++
 rtl/mdu.sv | 94 +++++++++
 tb/tb_mdu.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared opcodes, read selects and FSM encoding for the multiply/divide unit.
package mdu_pkg;

  localparam logic [2:0] MDU_OP_MULT  = 3'd0;
  localparam logic [2:0] MDU_OP_MULTU = 3'd1;
  localparam logic [2:0] MDU_OP_DIV   = 3'd2;
  localparam logic [2:0] MDU_OP_DIVU  = 3'd3;
  localparam logic [2:0] MDU_OP_MTHI  = 3'd4;
  localparam logic [2:0] MDU_OP_MTLO  = 3'd5;

  localparam logic MDU_READ_LO = 1'b0;
  localparam logic MDU_READ_HI = 1'b1;

  typedef enum logic {
    MDU_STATE_IDLE = 1'b0,
    MDU_STATE_BUSY = 1'b1
  } mdu_state_t;

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MDU_OP_DIV) || (op == MDU_OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational HI/LO result for MULT/MULTU/DIV/DIVU; flags divide by zero.
// Signed divide works on magnitudes so 0x80000000 / -1 needs no special case.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] pend_hi,
  output logic [31:0] pend_lo,
  output logic        div_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] div_b;
  logic [31:0] mag_q;
  logic [31:0] mag_r;
  logic [31:0] uq;
  logic [31:0] ur;

  // Low 64 bits of a product of sign-extended operands equal the signed product.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  assign abs_a = a[31] ? (~a + 32'd1) : a;
  assign abs_b = b[31] ? (~b + 32'd1) : b;
  assign div_b = (b == 32'd0) ? 32'd1 : b;

  assign mag_q = abs_a / ((abs_b == 32'd0) ? 32'd1 : abs_b);
  assign mag_r = abs_a % ((abs_b == 32'd0) ? 32'd1 : abs_b);
  assign uq    = a / div_b;
  assign ur    = a % div_b;

  assign div_zero = is_div_op(op) && (b == 32'd0);

  always_comb begin
    pend_hi = 32'd0;
    pend_lo = 32'd0;
    case (op)
      MDU_OP_MULT: begin
        pend_hi = prod_s[63:32];
        pend_lo = prod_s[31:0];
      end
      MDU_OP_MULTU: begin
        pend_hi = prod_u[63:32];
        pend_lo = prod_u[31:0];
      end
      MDU_OP_DIV: begin
        pend_lo = (a[31] ^ b[31]) ? (~mag_q + 32'd1) : mag_q;
        pend_hi = a[31] ? (~mag_r + 32'd1) : mag_r;
      end
      MDU_OP_DIVU: begin
        pend_lo = uq;
        pend_hi = ur;
      end
      default: begin
        pend_hi = 32'd0;
        pend_lo = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/mdu.sv
// EX-stage multiply/divide unit: results land in HI/LO after a fixed busy window.
// Start while busy is dropped; the hazard controller stalls on MDU_o_Busy.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        MDU_i_clk,
  input  logic        MDU_i_reset,
  input  logic        MDU_i_Start,
  input  logic [2:0]  MDU_i_Op,
  input  logic [31:0] MDU_i_A,
  input  logic [31:0] MDU_i_B,
  input  logic        MDU_i_ReadSel,
  output logic        MDU_o_Busy,
  output logic [31:0] MDU_o_Output
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  mdu_state_t  state;
  logic [CW-1:0] cnt;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_divz;
  logic [31:0] calc_hi;
  logic [31:0] calc_lo;
  logic        calc_divz;

  mdu_calc u_calc (
    .op       (MDU_i_Op),
    .a        (MDU_i_A),
    .b        (MDU_i_B),
    .pend_hi  (calc_hi),
    .pend_lo  (calc_lo),
    .div_zero (calc_divz)
  );

  always_ff @(posedge MDU_i_clk) begin
    if (MDU_i_reset) begin
      state      <= MDU_STATE_IDLE;
      MDU_o_Busy <= 1'b0;
      cnt        <= '0;
      hi         <= 32'd0;
      lo         <= 32'd0;
      pend_hi    <= 32'd0;
      pend_lo    <= 32'd0;
      pend_divz  <= 1'b0;
    end else begin
      case (state)
        MDU_STATE_IDLE: begin
          if (MDU_i_Start) begin
            case (MDU_i_Op)
              MDU_OP_MULT, MDU_OP_MULTU, MDU_OP_DIV, MDU_OP_DIVU: begin
                pend_hi    <= calc_hi;
                pend_lo    <= calc_lo;
                pend_divz  <= calc_divz;
                cnt        <= is_div_op(MDU_i_Op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                state      <= MDU_STATE_BUSY;
                MDU_o_Busy <= 1'b1;
              end
              MDU_OP_MTHI: hi <= MDU_i_A;
              MDU_OP_MTLO: lo <= MDU_i_A;
              default: ;
            endcase
          end
        end
        MDU_STATE_BUSY: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state      <= MDU_STATE_IDLE;
            MDU_o_Busy <= 1'b0;
            // Divide by zero still burns the full window but leaves HI/LO alone.
            if (!pend_divz) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
          end
        end
        default: begin
          state      <= MDU_STATE_IDLE;
          MDU_o_Busy <= 1'b0;
        end
      endcase
    end
  end

  assign MDU_o_Output = (MDU_i_ReadSel == MDU_READ_HI) ? hi : lo;

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu: busy window length, HI/LO results, reset abort.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        rsel = 1'b0;
  logic        busy;
  logic [31:0] dout;

  int total = 0;
  int passed = 0;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .MDU_i_clk     (clk),
    .MDU_i_reset   (reset),
    .MDU_i_Start   (start),
    .MDU_i_Op      (op),
    .MDU_i_A       (a),
    .MDU_i_B       (b),
    .MDU_i_ReadSel (rsel),
    .MDU_o_Busy    (busy),
    .MDU_o_Output  (dout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  task automatic rd(input logic sel, output logic [31:0] v);
    rsel = sel;
    #1;
    v = dout;
  endtask

  task automatic chk_hilo(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
    logic [31:0] v;
    rd(MDU_READ_HI, v);
    chk({tag, "_hi"}, v, ehi);
    rd(MDU_READ_LO, v);
    chk({tag, "_lo"}, v, elo);
  endtask

  // Single-cycle request; operands are scrambled afterwards to prove they are latched.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    tick();
    start = 1'b0;
    a = 32'hDEAD_BEEF;
    b = 32'h0BAD_F00D;
  endtask

  // Counts busy cycles seen after the start edge, bounded so a stuck DUT still ends.
  task automatic busy_len(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
  endtask

  initial begin
    int n;
    logic [31:0] v;

    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk_hilo("reset", 32'd0, 32'd0);

    issue(MDU_OP_MULT, 32'hFFFF_FFFD, 32'd5);
    rd(MDU_READ_LO, v);
    chk("mult_old_lo_during_busy", v, 32'd0);
    busy_len(n);
    chk("mult_busy_cycles", n, 32'd5);
    chk_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1);

    issue(MDU_OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    busy_len(n);
    chk("multu_busy_cycles", n, 32'd5);
    chk_hilo("multu", 32'h0000_0001, 32'hFFFF_FFFE);

    issue(MDU_OP_DIV, 32'hFFFF_FFF9, 32'd2);
    busy_len(n);
    chk("div_busy_cycles", n, 32'd10);
    chk_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    issue(MDU_OP_MTHI, 32'h11, 32'd0);
    chk("mthi_no_busy", {31'd0, busy}, 32'd0);
    issue(MDU_OP_MTLO, 32'h22, 32'd0);
    chk_hilo("mt_preload", 32'h11, 32'h22);

    issue(MDU_OP_DIVU, 32'd7, 32'd0);
    busy_len(n);
    chk("divz_busy_cycles", n, 32'd10);
    chk_hilo("divz", 32'h11, 32'h22);

    issue(MDU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    busy_len(n);
    chk_hilo("div_ovf", 32'd0, 32'h8000_0000);

    issue(MDU_OP_DIVU, 32'hFFFF_FFFF, 32'd10);
    busy_len(n);
    chk_hilo("divu", 32'd5, 32'h1999_9999);

    issue(MDU_OP_DIV, 32'd7, 32'hFFFF_FFFE);
    busy_len(n);
    chk_hilo("div_negb", 32'd1, 32'hFFFF_FFFD);

    issue(3'd7, 32'h1234_5678, 32'h9);
    chk("undef_no_busy", {31'd0, busy}, 32'd0);
    chk_hilo("undef", 32'd1, 32'hFFFF_FFFD);

    // MULTU 3*4, then an MTHI arriving on busy cycle 2 must be dropped.
    issue(MDU_OP_MULTU, 32'd3, 32'd4);
    tick();
    issue(MDU_OP_MTHI, 32'h0000_ABCD, 32'd0);
    chk("busy_during_ignored_mthi", {31'd0, busy}, 32'd1);
    busy_len(n);
    chk("ignored_mthi_remaining_busy", n, 32'd3);
    chk_hilo("ignored_mthi", 32'd0, 32'hC);

    // Reset on busy cycle 4 aborts the divide with no late commit.
    issue(MDU_OP_DIV, 32'd100, 32'd7);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk_hilo("abort", 32'd0, 32'd0);
    for (int i = 0; i < 12; i++) tick();
    chk("abort_late_busy", {31'd0, busy}, 32'd0);
    chk_hilo("abort_late", 32'd0, 32'd0);
    issue(MDU_OP_MTLO, 32'd5, 32'd0);
    chk_hilo("post_abort_mtlo", 32'd0, 32'd5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
